unified_mem_arbiter: RTL
========================

# unified_mem_arbiter

Arbitrates a single-ported unified memory between the instruction-fetch requester (IF stage, read-only) and the data requester (MEM stage, load/store) of the pipelined core. Each transaction is a request/acknowledge handshake on the memory side. Results are returned through one-cycle done pulses. Stall outputs freeze the affected pipeline stages while their access is outstanding. The data port has priority, with a starvation guard so fetch always makes progress.

## Interface
- ADDR_W, 64, address width of both requesters and memory
- DATA_W, 64, data width
- STARVE_MAX, 3, number of consecutive data grants allowed while fetch is waiting (1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request level; held until i_done
- i_addr  in  ADDR_W  fetch address, stable while i_req high
- i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  DATA_W  fetched word, held until the next i_done
- d_req  in  1  data request level; held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  load data, held until the next load d_done
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, single-cycle
- if_stall  out  1  combinational: i_req & ~i_done
- mem_stall  out  1  combinational: d_req & ~d_done

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. Reset state is IDLE.
- **IDLE, grant decision:**
  - Only d_req high → data.
  - Only i_req high → fetch.
  - Both high → data, unless starve_cnt == STARVE_MAX, in which case fetch.
- **On grant:**
  - Register mem_req=1, plus mem_addr, mem_we and mem_wdata from the granted port.
  - mem_we=0 for fetch.
  - mem_wdata is don't-care for loads and fetches, but is driven from d_wdata/0 deterministically.
  - Next state is BUSY_I or BUSY_D.
- **starve_cnt (4 bits):**
  - +1 on a data grant while i_req is high.
  - Cleared on a fetch grant or when i_req is low in IDLE.
  - Saturates at STARVE_MAX.
- **BUSY_x:** hold the mem_* outputs constant. When mem_ack is sampled high:
  - Drop mem_req.
  - Capture mem_rdata into i_rdata, or into d_rdata for loads only; stores do not update d_rdata.
  - Pulse the owner's done for one cycle.
  - Return to IDLE.
- A requester's req level during its done cycle counts as a new request. Back-to-back fetches therefore need no deassertion.
- mem_ack in IDLE is ignored (protocol error) and causes no state change.
- **Reset (asserted at any time, including mid-transaction):**
  - mem_req, mem_we, mem_addr, mem_wdata, i_done, d_done, i_rdata and d_rdata all go to 0 immediately.
  - starve_cnt goes to 0 and state goes to IDLE.
  - The in-flight transaction is abandoned and never reported.
  - After release, the first edge behaves as IDLE.

## Timing
- Grant edge E0: mem_req is high from E0.
- If the memory acks in the cycle after E0, the done pulse follows the ack edge. Minimum latency is 2 cycles from req to done; with an N-cycle memory, latency is N+1.
- Done pulses exactly one cycle after the edge that sampled mem_ack.
- Next grant happens in the same cycle as done, because the FSM is already IDLE. Peak throughput is one transaction per 2 cycles for a 1-cycle memory.
- i_done and d_done are never high together, and mem_req never covers two transactions without an IDLE cycle in between.
- Stall outputs are combinational, with no added latency.

## Test plan
- **Single fetch:** i_req=1, i_addr=0x10, memory acks 1 cycle after mem_req with 0x00500093. Required: mem_req high 1 cycle with mem_addr=0x10, mem_we=0; i_done pulses once with i_rdata=0x00500093; if_stall high until that cycle.
- **Simultaneous requests:** i_req and d_req rise together, d_we=1, d_addr=0x20, d_wdata=0xAB. Required: first transaction is a store with mem_we=1, mem_wdata=0xAB; d_done first, d_rdata unchanged; fetch served next with i_done.
- **Starvation guard:** STARVE_MAX=3, i_req held, five back-to-back loads. Required: order is D, D, D, I, D, D; starve_cnt returns to 0 after the fetch grant.
- **Variable memory latency:** mem_ack delayed 5 cycles. Required: mem_* stable for all 5 cycles, done exactly 1 cycle after ack, no second mem_req issued.
- **Reset mid-transaction:** reset low while in BUSY_D before ack. Required: mem_req=0 and all outputs 0 asynchronously, no d_done after release; with d_req still high, a fresh grant on the first edge after release.
- **Stray ack:** mem_ack pulsed in IDLE with no requests. Required: no done pulse, state stays IDLE, mem_req stays 0.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Single-ported memory arbiter between instruction fetch and the load/store port.
// Data wins ties unless fetch has already waited STARVE_MAX consecutive data grants.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              if_stall,
    output logic              mem_stall,
    output logic [1:0]        state_dbg,
    output logic [3:0]        starve_cnt_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    state_t            state, state_nxt;
    logic [3:0]        starve_cnt, starve_cnt_nxt;
    logic              mem_req_nxt, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              i_done_nxt, d_done_nxt;
    logic [DATA_W-1:0] i_rdata_nxt, d_rdata_nxt;
    logic              grant_d, grant_i;

    // Handshake: a requester holds *_req (address/data stable) until its one-cycle *_done;
    // mem_req and all mem_* stay constant until the single-cycle mem_ack is sampled.
    assign grant_d = d_req & (~i_req | (starve_cnt != STARVE_LIMIT));
    assign grant_i = i_req & ~grant_d;

    assign if_stall       = i_req & ~i_done;
    assign mem_stall      = d_req & ~d_done;
    assign state_dbg      = state;
    assign starve_cnt_dbg = starve_cnt;

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        mem_req_nxt    = mem_req;
        mem_we_nxt     = mem_we;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        i_rdata_nxt    = i_rdata;
        d_rdata_nxt    = d_rdata;
        i_done_nxt     = 1'b0;
        d_done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                // A stray mem_ack here is a protocol error and is simply ignored.
                if (!i_req) begin
                    starve_cnt_nxt = '0;
                end
                if (grant_d) begin
                    state_nxt     = BUSY_D;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = d_we;
                    mem_addr_nxt  = d_addr;
                    mem_wdata_nxt = d_wdata;
                    if (i_req && (starve_cnt != STARVE_LIMIT)) begin
                        starve_cnt_nxt = starve_cnt + 4'd1;
                    end
                end else if (grant_i) begin
                    state_nxt      = BUSY_I;
                    mem_req_nxt    = 1'b1;
                    mem_we_nxt     = 1'b0;
                    mem_addr_nxt   = i_addr;
                    mem_wdata_nxt  = '0;
                    starve_cnt_nxt = '0;
                end
            end
            BUSY_I: begin
                if (mem_ack) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    i_done_nxt  = 1'b1;
                    i_rdata_nxt = mem_rdata;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    d_done_nxt  = 1'b1;
                    // Stores leave the last load result untouched.
                    if (!mem_we) begin
                        d_rdata_nxt = mem_rdata;
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            i_done     <= i_done_nxt;
            d_done     <= d_done_nxt;
            i_rdata    <= i_rdata_nxt;
            d_rdata    <= d_rdata_nxt;
        end
    end

endmodule
